// File: rtl/ibex_ahb_pkg.sv
// Shared constants and types for the Ibex-to-AHB-Lite bridge.
// - HTRANS / HBURST / HSIZE encodings used on the AHB master port.
// - owner_e: which core port currently owns the AHB address phase.
// - be_to_hsize: maps a data-port byte-enable pattern to an AHB transfer size.
package ibex_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Aligned halfwords and single bytes get a narrow size; every other
  // pattern (including all-zero) is issued as a full word.
  function automatic logic [2:0] be_to_hsize(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return HSIZE_BYTE;
      4'b0011, 4'b1100:                   return HSIZE_HALF;
      default:                            return HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ibex_ahb_arbiter.sv
// Fixed-priority arbiter with AHB stall lock.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   instr_req         instruction-port request
//   data_req          data-port request (wins over instr_req)
//   hready            AHB ready; while low the previous owner is held
//   sel               owner of the current address phase
module ibex_ahb_arbiter
  import ibex_ahb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   instr_req,
  input  logic   data_req,
  input  logic   hready,
  output owner_e sel
);

  owner_e owner_q;

  // A stalled address phase must stay exactly as it was, so arbitration is
  // frozen on the registered owner (even OWN_NONE) until HREADY returns.
  always_comb begin
    // NOTE: default assignment first so every path drives sel; no latch.
    sel = OWN_NONE;
    if (rst_n) begin
      if (!hready)        sel = owner_q;
      else if (data_req)  sel = OWN_DATA;
      else if (instr_req) sel = OWN_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state.
    if (!rst_n) owner_q <= OWN_NONE;
    else        owner_q <= sel;
  end

endmodule

// File: rtl/ibex_ahb_lite_bridge.sv
// Bridges Ibex instruction and data request ports onto one AHB-Lite master.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   instr_req_o, instr_addr_o          instruction fetch request (inputs)
//   data_req_o, data_we_o, data_be_o,
//   data_addr_o, data_wdata_o          data load/store request (inputs)
//   instr_rvalid_i, instr_rdata_i,
//   data_rvalid_i, data_rdata_i        reserved, ignored
//   instr_gnt_i, data_gnt_i            grants back to the core (outputs)
//   HTRANS, HSIZE_out, HADDR_out,
//   HBURST, HWRITE, HWDATA             AHB-Lite master outputs
//   HRDATA, HREADY                     AHB-Lite inputs (HRDATA unused)
module ibex_ahb_lite_bridge
  import ibex_ahb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_o,
  input  logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        data_req_o,
  input  logic        data_we_o,
  input  logic [3:0]  data_be_o,
  input  logic [31:0] data_addr_o,
  input  logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        instr_gnt_i,
  output logic        data_gnt_i,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE_out,
  output logic [31:0] HADDR_out,
  output logic [2:0]  HBURST,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  owner_e      sel;
  logic        addr_valid;
  logic        gnt;

  owner_e      dphase_owner_q;
  logic        dphase_write_q;
  logic [31:0] dphase_wdata_q;

  logic        unused_reserved;
  assign unused_reserved = ^{instr_rvalid_i, instr_rdata_i, data_rvalid_i,
                             data_rdata_i, HRDATA};

  ibex_ahb_arbiter u_arbiter (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .instr_req (instr_req_o),
    .data_req  (data_req_o),
    .hready    (HREADY),
    .sel       (sel)
  );

  // The held owner may have dropped its request during a stall; the address
  // phase is only live while the owner is actually requesting.
  assign addr_valid = rst_ni && ((sel == OWN_DATA  && data_req_o) ||
                                 (sel == OWN_INSTR && instr_req_o));

  assign instr_gnt_i = addr_valid && (sel == OWN_INSTR) && HREADY;
  assign data_gnt_i  = addr_valid && (sel == OWN_DATA)  && HREADY;
  assign gnt         = instr_gnt_i || data_gnt_i;

  // Address phase, combinational from the selected port.
  always_comb begin
    HTRANS    = HTRANS_IDLE;
    HADDR_out = '0;
    HWRITE    = 1'b0;
    HSIZE_out = HSIZE_WORD;
    if (addr_valid) begin
      HTRANS = HTRANS_NONSEQ;
      if (sel == OWN_DATA) begin
        HADDR_out = data_addr_o;
        HWRITE    = data_we_o;
        HSIZE_out = be_to_hsize(data_be_o);
      end else begin
        HADDR_out = instr_addr_o;
      end
    end
  end

  assign HBURST = HBURST_SINGLE;

  // Data-phase registers load only on a grant, and a grant needs HREADY, so
  // they naturally hold through wait states.
  always_ff @(posedge clk_i) begin
    // NOTE: every data-phase register is cleared in reset so HWDATA is 0 after it.
    if (!rst_ni) begin
      dphase_owner_q <= OWN_NONE;
      dphase_write_q <= 1'b0;
      dphase_wdata_q <= '0;
    end else if (gnt) begin
      dphase_owner_q <= sel;
      dphase_write_q <= HWRITE;
      dphase_wdata_q <= data_wdata_o;
    end
  end

  assign HWDATA = (rst_ni && dphase_owner_q == OWN_DATA && dphase_write_q)
                  ? dphase_wdata_q : '0;

endmodule

// File: tb/tb_ibex_ahb_lite_bridge.sv
module tb_ibex_ahb_lite_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        instr_gnt_i;
  logic        data_gnt_i;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE_out;
  logic [31:0] HADDR_out;
  logic [2:0]  HBURST;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  always #5 clk_i = ~clk_i;

  ibex_ahb_lite_bridge dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i),
    .instr_gnt_i    (instr_gnt_i),
    .data_gnt_i     (data_gnt_i),
    .HTRANS         (HTRANS),
    .HSIZE_out      (HSIZE_out),
    .HADDR_out      (HADDR_out),
    .HBURST         (HBURST),
    .HWRITE         (HWRITE),
    .HWDATA         (HWDATA),
    .HRDATA         (HRDATA),
    .HREADY         (HREADY)
  );

  typedef struct {
    logic        ig;
    logic        dg;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  bit stim_done = 0;

  // Reference state: who owned the bus in the last cycle (0 none, 1 instr,
  // 2 data) and what the write-data bus must show.
  int          m_owner   = 0;
  logic [31:0] m_hwdata  = '0;
  int          nx_owner  = 0;
  logic [31:0] nx_hwdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] size_of(input logic [3:0] be);
    if ($countones(be) == 1)          return 3'd0;
    else if (be == 4'h3 || be == 4'hC) return 3'd1;
    else                               return 3'd2;
  endfunction

  // One bus cycle: commit the previous cycle to the model, drive inputs just
  // after the edge and queue what the bridge must show during this cycle.
  task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic we, input logic [3:0] be,
                      input logic [31:0] daddr, input logic [31:0] wdata,
                      input logic hr);
    exp_t e;
    int   own;
    logic live;
    @(posedge clk_i);
    m_owner  = nx_owner;
    m_hwdata = nx_hwdata;
    #1;
    rst_ni = rst; instr_req_o = ireq; instr_addr_o = iaddr;
    data_req_o = dreq; data_we_o = we; data_be_o = be;
    data_addr_o = daddr; data_wdata_o = wdata; HREADY = hr;
    HRDATA = $urandom; instr_rdata_i = $urandom; data_rdata_i = $urandom;
    instr_rvalid_i = 1'($urandom); data_rvalid_i = 1'($urandom);

    e = '{ig: 0, dg: 0, htrans: 2'b00, hsize: 3'd2, haddr: 0, hwrite: 0, hwdata: 0};
    if (!rst) begin
      nx_owner  = 0;
      nx_hwdata = '0;
    end else begin
      own  = hr ? (dreq ? 2 : (ireq ? 1 : 0)) : m_owner;
      live = (own == 2) ? dreq : ((own == 1) ? ireq : 1'b0);
      e.hwdata = m_hwdata;
      if (live) begin
        e.htrans = 2'b10;
        e.haddr  = (own == 2) ? daddr : iaddr;
        e.hwrite = (own == 2) && we;
        e.hsize  = (own == 2) ? size_of(be) : 3'd2;
        e.ig     = hr && own == 1;
        e.dg     = hr && own == 2;
      end
      nx_owner  = own;
      nx_hwdata = m_hwdata;
      if (e.ig || e.dg) nx_hwdata = e.hwrite ? wdata : 32'h0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares away from the active edge, popping one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("instr_gnt", 32'(instr_gnt_i), 32'(e.ig));
        check("data_gnt",  32'(data_gnt_i),  32'(e.dg));
        check("htrans",    32'(HTRANS),      32'(e.htrans));
        check("hsize",     32'(HSIZE_out),   32'(e.hsize));
        check("haddr",     HADDR_out,        e.haddr);
        check("hwrite",    32'(HWRITE),      32'(e.hwrite));
        check("hwdata",    HWDATA,           e.hwdata);
        check("hburst",    32'(HBURST),      32'h0);
      end
    end
  end

  initial begin
    rst_ni = 0; instr_req_o = 0; instr_addr_o = 0; data_req_o = 0; data_we_o = 0;
    data_be_o = 0; data_addr_o = 0; data_wdata_o = 0; HREADY = 1; HRDATA = 0;
    instr_rvalid_i = 0; instr_rdata_i = 0; data_rvalid_i = 0; data_rdata_i = 0;

    // Reset with a pending fetch: nothing leaves the bridge.
    repeat (3) step(0, 1, 32'h4, 0, 0, 4'h0, 0, 0, 1);
    // Both request, data wins; be=0000 is a word.
    step(1, 1, 32'h4, 1, 0, 4'h0, 32'h6, 0, 1);
    // Instruction only.
    step(1, 1, 32'h4, 0, 0, 4'h0, 0, 0, 1);
    // Byte write, data shows up on the following cycle.
    step(1, 0, 0, 1, 1, 4'b0001, 32'h10, 32'hA5A5A5A5, 1);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    // Stall from idle: fetch pending, then data rises, then HREADY returns.
    step(1, 1, 32'h4, 0, 0, 4'h0, 0, 0, 0);
    step(1, 1, 32'h4, 1, 0, 4'hC, 32'h20, 0, 0);
    step(1, 1, 32'h4, 1, 0, 4'hC, 32'h20, 0, 1);
    // Fetch granted, then a stall holds the fetch address despite data_req.
    step(1, 1, 32'h8, 0, 0, 4'h0, 0, 0, 1);
    step(1, 1, 32'hC, 1, 1, 4'hF, 32'h30, 32'h1234_5678, 0);
    step(1, 1, 32'hC, 1, 1, 4'hF, 32'h30, 32'h1234_5678, 0);
    step(1, 1, 32'hC, 1, 1, 4'hF, 32'h30, 32'h1234_5678, 1);
    // Idle: HWDATA keeps the last written value.
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    // Reset in the middle of a stream of requests.
    step(1, 0, 0, 1, 1, 4'h3, 32'h40, 32'hDEAD_BEEF, 1);
    step(0, 1, 32'h44, 1, 1, 4'h3, 32'h44, 32'hCAFE_F00D, 1);
    step(1, 1, 32'h48, 0, 0, 4'h0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) >= 4), 1'($urandom), $urandom,
           1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), $urandom,
           $urandom, ($urandom_range(0, 99) < 70));
    end
    stim_done = 1;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
